// File: rtl/macgen_chunker.sv
// Byte-to-chunk packer feeding the MAC generator; pads the final partial chunk.
// Latency: out_valid the cycle after the 32nd or in_last byte; in_ready returns the cycle after the out handshake.
// Backpressure: in_ready is low while a chunk is held; the chunk stays stable until out_ready.
module macgen_chunker #(
    parameter int         CHUNK_BYTES = 32,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_byte,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*CHUNK_BYTES-1:0] out_data,
    output logic [5:0]               out_nbytes,
    output logic                     out_first,
    output logic                     out_last
);

    localparam int         W         = 8 * CHUNK_BYTES;
    localparam logic [0:0] ST_FILL   = 1'b0;
    localparam logic [0:0] ST_HOLD   = 1'b1;
    localparam logic [5:0] LAST_LANE = 6'(CHUNK_BYTES - 1);

    typedef struct packed {
        logic [5:0] nbytes;
        logic       first;
        logic       last;
    } meta_t;

    logic [0:0]   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         first_q, first_d;
    logic [W-1:0] data_q, data_d;
    meta_t        meta_q, meta_d;

    logic in_fire;
    logic out_fire;
    logic chunk_done;

    assign in_ready   = (state_q == ST_FILL);
    assign out_valid  = (state_q == ST_HOLD);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign chunk_done = in_fire && ((cnt_q == LAST_LANE) || in_last);

    assign out_data   = data_q;
    assign out_nbytes = meta_q.nbytes;
    assign out_first  = meta_q.first;
    assign out_last   = meta_q.last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        data_d  = data_q;
        meta_d  = meta_q;

        if (in_fire) begin
            for (int i = 0; i < CHUNK_BYTES; i++) begin
                if (cnt_q == 6'(i)) begin
                    data_d[8*i +: 8] = in_byte;
                end
            end
            cnt_d = cnt_q + 6'd1;
            if (chunk_done) begin
                state_d       = ST_HOLD;
                meta_d.nbytes = cnt_q + 6'd1;
                meta_d.first  = first_q;
                meta_d.last   = in_last;
            end
        end

        // Lanes are wiped on release so the next chunk's unfilled lanes read as padding.
        if (out_fire) begin
            state_d = ST_FILL;
            cnt_d   = 6'd0;
            first_d = meta_q.last;
            data_d  = {CHUNK_BYTES{PAD_BYTE}};
            meta_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= 6'd0;
            first_q <= 1'b1;
            data_q  <= {CHUNK_BYTES{PAD_BYTE}};
            meta_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            data_q  <= data_d;
            meta_q  <= meta_d;
        end
    end

endmodule

// File: tb/tb_macgen_chunker.sv
// Bench for macgen_chunker: vector table, hand-written corner sequences and random messages vs a chunk-level model.
module tb_macgen_chunker;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_byte = 8'h00;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_data;
    logic [5:0]   out_nbytes;
    logic         out_first;
    logic         out_last;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    int chunk_cnt = 0;
    logic [255:0] last_data = '0;
    logic [5:0]   last_n = '0;

    typedef struct {
        logic [255:0] d;
        logic [5:0]   n;
        logic         f;
        logic         l;
    } chunk_t;

    typedef struct {
        int         len;
        logic [7:0] base;
        logic [7:0] step;
        bit         gap;
        int         exp_chunks;
        logic [5:0] exp_last_n;
    } vec_t;

    chunk_t     exp_q[$];
    chunk_t     mon_e;
    logic [7:0] msg[$];

    always #5 clk = ~clk;

    macgen_chunker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nbytes(out_nbytes),
        .out_first (out_first),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // A chunk as a message slice: real bytes in the low lanes, zero padding above.
    function automatic chunk_t make_chunk(input int start, input int n, input logic f, input logic l);
        chunk_t c;
        c.d = '0;
        for (int i = 0; i < n; i++) c.d[8*i +: 8] = msg[start + i];
        c.n = 6'(n);
        c.f = f;
        c.l = l;
        return c;
    endfunction

    function automatic void model_msg();
        int len = msg.size();
        int nch = (len + 31) / 32;
        for (int k = 0; k < nch; k++) begin
            int n = (len - 32*k > 32) ? 32 : len - 32*k;
            exp_q.push_back(make_chunk(32*k, n, k == 0, k == nch - 1));
        end
    endfunction

    // Handshake inputs are stable from #1 after posedge, so negedge sees what the next edge will take.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_chunk actual nbytes=%0d expected no chunk", out_nbytes);
            end else begin
                mon_e = exp_q.pop_front();
                chk("chunk_data",   out_data,           mon_e.d);
                chk("chunk_nbytes", 256'(out_nbytes),   256'(mon_e.n));
                chk("chunk_first",  256'(out_first),    256'(mon_e.f));
                chk("chunk_last",   256'(out_last),     256'(mon_e.l));
            end
            chunk_cnt++;
            last_data = out_data;
            last_n    = out_nbytes;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic l, input logic exp_ov);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        while (!in_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("out_valid_after_byte", 256'(out_valid), 256'(exp_ov));
    endtask

    task automatic send_msg(input bit gap, input bit with_last);
        int len = msg.size();
        for (int i = 0; i < len; i++) begin
            logic lb;
            lb = with_last && (i == len - 1);
            send_byte(msg[i], lb, (i % 32 == 31) || lb);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        vec_t   vecs[7];
        chunk_t e;
        int     c0;

        vecs[0] = '{32, 8'h00, 8'h01, 1'b0, 1, 6'd32};
        vecs[1] = '{5,  8'hA1, 8'h11, 1'b0, 1, 6'd5};
        vecs[2] = '{40, 8'h00, 8'h01, 1'b0, 2, 6'd8};
        vecs[3] = '{33, 8'h00, 8'h01, 1'b1, 2, 6'd1};
        vecs[4] = '{64, 8'h40, 8'h03, 1'b0, 2, 6'd32};
        vecs[5] = '{1,  8'h5A, 8'h00, 1'b0, 1, 6'd1};
        vecs[6] = '{31, 8'h10, 8'h07, 1'b1, 1, 6'd31};

        rdy_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  256'(in_ready),   256'(1));
        chk("rst_out_valid", 256'(out_valid),  256'(0));
        chk("rst_out_data",  out_data,         256'(0));
        chk("rst_nbytes",    256'(out_nbytes), 256'(0));
        chk("rst_first",     256'(out_first),  256'(0));
        chk("rst_last",      256'(out_last),   256'(0));
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 256'(in_ready), 256'(1));

        for (int v = 0; v < 7; v++) begin
            msg.delete();
            for (int i = 0; i < vecs[v].len; i++) msg.push_back(8'(vecs[v].base + vecs[v].step * i));
            model_msg();
            c0 = chunk_cnt;
            send_msg(vecs[v].gap, 1'b1);
            wait_drain();
            chk("vec_nchunks", 256'(chunk_cnt - c0), 256'(vecs[v].exp_chunks));
            chk("vec_last_n",  256'(last_n),         256'(vecs[v].exp_last_n));
            if (v == 0) chk("full_chunk_literal", last_data,
                256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100);
            if (v == 1) begin
                chk("short_low_lanes",  256'(last_data[39:0]), 256'(40'hE5D4C3B2A1));
                chk("short_high_lanes", 256'(last_data[255:40]), 256'(0));
            end
            if (v == 3) chk("gapped_lane0", 256'(last_data[7:0]), 256'(8'h20));
        end

        // Backpressure: chunk held for 10 cycles while a new byte waits upstream.
        rdy_mode = 3;
        out_ready = 1'b0;
        msg.delete();
        for (int i = 0; i < 5; i++) msg.push_back(8'(8'h31 + i));
        e = make_chunk(0, 5, 1'b1, 1'b1);
        exp_q.push_back(e);
        send_msg(1'b0, 1'b1);
        in_valid = 1'b1;
        in_byte  = 8'h77;
        in_last  = 1'b1;
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", 256'(out_valid),  256'(1));
            chk("hold_in_ready",  256'(in_ready),   256'(0));
            chk("hold_data",      out_data,         e.d);
            chk("hold_nbytes",    256'(out_nbytes), 256'(e.n));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", 256'(out_valid), 256'(0));
        chk("release_in_ready",  256'(in_ready),  256'(1));
        msg.delete();
        msg.push_back(8'h77);
        model_msg();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("held_byte_chunk_valid", 256'(out_valid), 256'(1));
        rdy_mode = 0;
        wait_drain();

        // Reset in the middle of a message's second chunk, then a fresh 3-byte message.
        msg.delete();
        for (int i = 0; i < 36; i++) msg.push_back(8'(8'h80 + i));
        exp_q.push_back(make_chunk(0, 32, 1'b1, 1'b0));
        send_msg(1'b0, 1'b0);
        wait_drain();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 256'(out_valid),  256'(0));
        chk("midrst_in_ready",  256'(in_ready),   256'(1));
        chk("midrst_out_data",  out_data,         256'(0));
        chk("midrst_nbytes",    256'(out_nbytes), 256'(0));
        rst_n = 1'b1;
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        model_msg();
        send_msg(1'b0, 1'b1);
        wait_drain();
        chk("after_rst_n",    256'(last_n), 256'(3));
        chk("after_rst_data", last_data,    256'(24'h636261));

        // Random messages, random gaps, random downstream readiness.
        rdy_mode = 1;
        for (int m = 0; m < 25; m++) begin
            int len;
            len = $urandom_range(1, 80);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
            model_msg();
            send_msg(1'($urandom_range(0, 1)), 1'b1);
            wait_drain();
        end
        rdy_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
